// File: rtl/pipe_sequencer.sv
// PC sequencer and hazard controller for the 5-stage pipeline: fetch PC, stage valids, enables, forwarding selects.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined; otherwise cnt_* read as zero.
module pipe_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter int              RA_W     = 5,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_ext,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  ex_rs,
    input  logic [RA_W-1:0]  ex_rt,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_regwrite,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_regwrite,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    output logic [PC_W-1:0]  pc,
    output logic [3:0]       stage_en,
    output logic [3:0]       stage_vld,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       pipe_state,
    output logic             retire,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_retire,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_STALL_LU = 2'b01,
        ST_REDIRECT = 2'b10,
        ST_FREEZE   = 2'b11
    } state_t;

    state_t          state_q;
    state_t          decision;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [3:0]      vld_q;
    logic [3:0]      vld_next;
    logic            redirect;
    logic            load_use;

    assign redirect = br_taken && vld_q[2];
    assign load_use = vld_q[0] && vld_q[1] && ex_memread && ex_regwrite && (ex_rd != '0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    // Redirect outranks an external freeze so a resolved branch is never lost.
    always_comb begin
        decision = ST_RUN;
        stage_en = 4'b1111;
        pc_next  = pc_q + PC_W'(1);
        vld_next = {vld_q[2:0], 1'b1};
        if (redirect) begin
            decision = ST_REDIRECT;
            pc_next  = br_target;
            vld_next = 4'b1000;
        end else if (stall_ext) begin
            decision = ST_FREEZE;
            stage_en = 4'b0000;
            pc_next  = pc_q;
            vld_next = vld_q;
        end else if (load_use) begin
            decision = ST_STALL_LU;
            stage_en = 4'b1110;
            pc_next  = pc_q;
            vld_next = {vld_q[2], vld_q[1], 1'b0, vld_q[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= PC_RESET;
            vld_q   <= 4'b0000;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_next;
            vld_q   <= vld_next;
            state_q <= decision;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (vld_q[2] && mem_regwrite && (mem_rd != '0) && (mem_rd == src))
            sel = 2'b10;
        else if (vld_q[3] && wb_regwrite && (wb_rd != '0) && (wb_rd == src))
            sel = 2'b01;
        return sel;
    endfunction

    assign fwd_a      = vld_q[1] ? fwd_sel(ex_rs) : 2'b00;
    assign fwd_b      = vld_q[1] ? fwd_sel(ex_rt) : 2'b00;
    assign pc         = pc_q;
    assign stage_vld  = vld_q;
    assign pipe_state = state_q;
    assign retire     = vld_q[3] && !stall_ext;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q, stl_q, fls_q;

    // Every counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_q <= '0;
            ret_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else begin
            if (cyc_q != '1)
                cyc_q <= cyc_q + CNT_W'(1);
            if (retire && (ret_q != '1))
                ret_q <= ret_q + CNT_W'(1);
            if (((decision == ST_STALL_LU) || (decision == ST_FREEZE)) && (stl_q != '1))
                stl_q <= stl_q + CNT_W'(1);
            if ((decision == ST_REDIRECT) && (fls_q != '1))
                fls_q <= fls_q + CNT_W'(1);
        end
    end

    assign cnt_cycle  = cyc_q;
    assign cnt_retire = ret_q;
    assign cnt_stall  = stl_q;
    assign cnt_flush  = fls_q;
`else
    assign cnt_cycle  = '0;
    assign cnt_retire = '0;
    assign cnt_stall  = '0;
    assign cnt_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: directed hazard scenarios then random traffic against a slot-level pipeline model.
// Counter expectations follow PIPE_PERF_CNT_EN the same way the design does.
module tb_pipe_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall_ext;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic       br_taken;
    logic [7:0] br_target;
    logic [7:0] pc;
    logic [3:0] stage_en, stage_vld;
    logic [1:0] fwd_a, fwd_b, pipe_state;
    logic       retire;
    logic [31:0] cnt_cycle, cnt_retire, cnt_stall, cnt_flush;

    int checks = 0;
    int errors = 0;

    // Reference: slot[k] says whether pipeline register k holds a live instruction.
    int          m_pc;
    bit          slot [4];
    int          m_state;
    logic [31:0] m_cyc, m_ret, m_stl, m_fls;

    pipe_sequencer #(.PC_W(8), .PC_RESET(8'h00), .RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall_ext(stall_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .stage_en(stage_en), .stage_vld(stage_vld),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pipe_state(pipe_state), .retire(retire),
        .cnt_cycle(cnt_cycle), .cnt_retire(cnt_retire), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_pc    = 0;
        m_state = 0;
        for (int k = 0; k < 4; k++) slot[k] = 0;
        m_cyc = 0; m_ret = 0; m_stl = 0; m_fls = 0;
    endtask

    // 0 run, 1 load-use stall, 2 redirect, 3 freeze
    function automatic int decide();
        bit hit;
        hit = (id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd);
        if (br_taken && slot[2]) return 2;
        if (stall_ext) return 3;
        if (slot[0] && slot[1] && ex_memread && ex_regwrite && ex_rd != 0 && hit) return 1;
        return 0;
    endfunction

    function automatic logic [1:0] fwdModel(input logic [4:0] src);
        if (!slot[1]) return 2'b00;
        if (slot[2] && mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (slot[3] && wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] packSlots();
        return {slot[3], slot[2], slot[1], slot[0]};
    endfunction

    task automatic checkOutput();
        int d;
        logic [3:0] en_exp;
        d = decide();
        en_exp = (d == 3) ? 4'h0 : (d == 1) ? 4'hE : 4'hF;
        cmp("pc", {24'h0, pc}, m_pc);
        cmp("stage_vld", {28'h0, stage_vld}, {28'h0, packSlots()});
        cmp("pipe_state", {30'h0, pipe_state}, m_state);
        cmp("stage_en", {28'h0, stage_en}, {28'h0, en_exp});
        cmp("fwd_a", {30'h0, fwd_a}, {30'h0, fwdModel(ex_rs)});
        cmp("fwd_b", {30'h0, fwd_b}, {30'h0, fwdModel(ex_rt)});
        cmp("retire", {31'h0, retire}, {31'h0, slot[3] && !stall_ext});
`ifdef PIPE_PERF_CNT_EN
        cmp("cnt_cycle", cnt_cycle, m_cyc);
        cmp("cnt_retire", cnt_retire, m_ret);
        cmp("cnt_stall", cnt_stall, m_stl);
        cmp("cnt_flush", cnt_flush, m_fls);
`else
        cmp("cnt_cycle", cnt_cycle, 0);
        cmp("cnt_retire", cnt_retire, 0);
        cmp("cnt_stall", cnt_stall, 0);
        cmp("cnt_flush", cnt_flush, 0);
`endif
    endtask

    // What the clock edge does to the reference, given the inputs currently applied.
    task automatic modelUpdate();
        int d;
        if (!reset) begin
            modelReset();
            return;
        end
        d = decide();
        m_cyc++;
        if (slot[3] && !stall_ext) m_ret++;
        if (d == 1 || d == 3) m_stl++;
        if (d == 2) m_fls++;
        case (d)
            0: begin
                for (int k = 3; k > 0; k--) slot[k] = slot[k-1];
                slot[0] = 1;
                m_pc = (m_pc + 1) % 256;
            end
            1: begin
                slot[3] = slot[2];
                slot[2] = slot[1];
                slot[1] = 0;
            end
            2: begin
                slot[3] = 1;
                slot[2] = 0; slot[1] = 0; slot[0] = 0;
                m_pc = br_target;
            end
            default: ;
        endcase
        m_state = d;
    endtask

    task automatic quiet();
        stall_ext = 0; br_taken = 0; br_target = 8'h00;
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    endtask

    task automatic applyStimulus();
        reset        = ($urandom_range(0, 59) != 0);
        stall_ext    = ($urandom_range(0, 7) == 0);
        br_taken     = ($urandom_range(0, 9) == 0);
        br_target    = 8'($urandom_range(0, 255));
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        id_use_rs    = 1'($urandom_range(0, 1));
        id_use_rt    = 1'($urandom_range(0, 1));
        ex_rs        = 5'($urandom_range(0, 3));
        ex_rt        = 5'($urandom_range(0, 3));
        ex_rd        = 5'($urandom_range(0, 3));
        ex_regwrite  = 1'($urandom_range(0, 1));
        ex_memread   = 1'($urandom_range(0, 1));
        mem_rd       = 5'($urandom_range(0, 3));
        mem_regwrite = 1'($urandom_range(0, 1));
        wb_rd        = 5'($urandom_range(0, 3));
        wb_regwrite  = 1'($urandom_range(0, 1));
    endtask

    task automatic runCycle();
        #2;
        checkOutput();
        modelUpdate();
        @(negedge clk);
    endtask

    initial begin
        quiet();
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        modelReset();

        // Reset held two cycles, then hazard-free fill.
        runCycle();
        runCycle();
        reset = 1;
        repeat (5) runCycle();

        // lw r3 in ID/EX, add r4,r3,r1 in IF/ID.
        ex_memread = 1; ex_regwrite = 1; ex_rd = 3;
        id_rs = 3; id_rt = 1; id_use_rs = 1; id_use_rt = 1;
        runCycle();
        quiet();
        ex_rs = 3; ex_rt = 1; mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1;
        runCycle();
        mem_regwrite = 0;
        repeat (2) runCycle();

        // Both later stages write r2: EX/MEM wins; then r0 destinations never forward.
        quiet();
        ex_rs = 2; ex_rt = 2; mem_rd = 2; mem_regwrite = 1; wb_rd = 2; wb_regwrite = 1;
        runCycle();
        mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
        runCycle();

        // Taken branch to 8'h40 from a full pipeline, with freeze requested in the same cycle.
        quiet();
        repeat (3) runCycle();
        br_taken = 1; br_target = 8'h40; stall_ext = 1;
        runCycle();
        quiet();
        repeat (4) runCycle();

        // External freeze for three cycles, then resume.
        stall_ext = 1;
        repeat (3) runCycle();
        stall_ext = 0;
        repeat (2) runCycle();

        // PC wraps from FF to 00.
        br_taken = 1; br_target = 8'hFE;
        runCycle();
        br_taken = 0;
        repeat (4) runCycle();

        // Reset asserted while a load-use stall is pending.
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
        runCycle();
        reset = 0;
        runCycle();
        quiet();
        reset = 1;
        repeat (3) runCycle();

        for (int n = 0; n < 500; n++) begin
            applyStimulus();
            runCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
